// File: rtl/xor_engine_pkg.sv
// Shared types and default sizing for the xor_engine_sched slice.
package xor_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } sched_state_e;

    localparam int STATS_CNT_W = 16;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

endpackage

// File: rtl/xor_engine_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        int k;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        k          = 0;
        // The first hit wins; later lanes in the rotated order are masked by gnt_any.
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (en && !gnt_any && req[k]) begin
                gnt_any       = 1'b1;
                gnt_onehot[k] = 1'b1;
                gnt_idx       = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/xor_engine_sched.sv
// Round-robin scheduler sharing one registered XOR unit among NUM_REQ requesters.
// Optional statistics outputs (op_count, op_parity) are built when XOR_ENGINE_STATS_EN is defined.
module xor_engine_sched
    import xor_engine_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_y,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
`ifdef XOR_ENGINE_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0]   op_count,
    output logic                     op_parity
`endif
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_EXEC = EXEC;
    localparam logic [1:0] ST_HOLD = HOLD;

    logic [1:0]         state;
    logic [IDW-1:0]     rr_ptr;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [IDW-1:0]     op_id;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic               arb_en;

    // Arbitration only runs in IDLE and out of reset, so req_ready is zero otherwise.
    assign arb_en    = (state == ST_IDLE) && rst_n;
    assign req_ready = gnt_onehot;
    assign busy      = (state != ST_IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .en         (arb_en),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A grant implies its lane is valid, so gnt_any is the handshake.
                    if (gnt_any) begin
                        op_a   <= req_a[gnt_idx*WIDTH +: WIDTH];
                        op_b   <= req_b[gnt_idx*WIDTH +: WIDTH];
                        op_id  <= gnt_idx;
                        rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_y     <= op_a ^ op_b;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef XOR_ENGINE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign op_parity = ^rsp_y;
`endif

endmodule

// File: tb/tb_xor_engine_sched.sv
// Scoreboard bench for xor_engine_sched: a cycle model predicts grants and responses.
module tb_xor_engine_sched;

    localparam int NR = 4;
    localparam int W  = 8;

    typedef struct {
        int         id;
        logic [7:0] y;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_y;
    logic [1:0]      rsp_id;
    logic            busy;
`ifdef XOR_ENGINE_STATS_EN
    logic [15:0]     op_count;
    logic            op_parity;
`endif

    int compared   = 0;
    int mismatched = 0;

    exp_t sb[$];
    int   acc_ids[$];
    logic [7:0] last_y;
    int   last_id;

    // Reference model state: 0 idle, 1 exec, 2 hold
    int         m_state = 0;
    int         m_ptr   = 0;
    int         m_g;
    logic [3:0] exp_rdy;

    xor_engine_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef XOR_ENGINE_STATS_EN
        ,
        .op_count  (op_count),
        .op_parity (op_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model checks the current cycle, then advances to the state after the next rising edge.
    always @(negedge clk) begin
        checkOutput("busy", {31'b0, busy}, {31'b0, m_state != 0});
        checkOutput("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_state == 2});
        if (m_state == 2) begin
            checkOutput("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                checkOutput("rsp_y", {24'b0, rsp_y}, {24'b0, sb[0].y});
                checkOutput("rsp_id", {30'b0, rsp_id}, sb[0].id);
            end
        end
        exp_rdy = 4'b0;
        m_g = -1;
        if (rst_n && m_state == 0) begin
            for (int k = 0; k < NR; k++) begin
                if (m_g < 0 && req_valid[(m_ptr + k) % NR]) m_g = (m_ptr + k) % NR;
            end
            if (m_g >= 0) exp_rdy[m_g] = 1'b1;
        end
        checkOutput("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
        if (!rst_n) begin
            m_state = 0;
            m_ptr   = 0;
            sb.delete();
        end else begin
            case (m_state)
                0: if (m_g >= 0) begin
                    sb.push_back('{id: m_g, y: req_a[m_g*W +: W] ^ req_b[m_g*W +: W]});
                    m_ptr   = (m_g + 1) % NR;
                    m_state = 1;
                end
                1: m_state = 2;
                default: if (rsp_ready) begin
                    last_y  = rsp_y;
                    last_id = int'(rsp_id);
                    acc_ids.push_back(int'(rsp_id));
                    if (sb.size() > 0) void'(sb.pop_front());
                    m_state = 0;
                end
            endcase
        end
    end

    task automatic waitReady(input int id);
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[id]) break;
        end
        if (n == 50) checkOutput("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
        waitReady(id);
    endtask

    task automatic waitIdle();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (m_state == 0 && sb.size() == 0) break;
        end
        if (n == 200) checkOutput("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] tt_exp [4];
        int rr_exp [5];
        logic [1:0] pv;

        tt_exp = '{8'h00, 8'h01, 8'h01, 8'h00};
        rr_exp = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_y", {24'b0, rsp_y}, 32'd0);
        checkOutput("rst_rsp_id", {30'b0, rsp_id}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_rr_ptr", {30'b0, dut.rr_ptr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] single request");
        applyStimulus(0, 8'hA5, 8'h0F);
        waitIdle();
        checkOutput("single_y", {24'b0, last_y}, 32'h0000_00AA);
        checkOutput("single_id", last_id, 32'd0);

        $display("[TB] truth table on requester 2");
        for (int p = 0; p < 4; p++) begin
            pv = 2'(p);
            applyStimulus(2, {7'b0, pv[1]}, {7'b0, pv[0]});
            waitIdle();
            checkOutput("tt_y", {24'b0, last_y}, {24'b0, tt_exp[p]});
            checkOutput("tt_id", last_id, 32'd2);
        end

        $display("[TB] round robin");
        doReset(2);
        base = acc_ids.size();
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = 8'(8'h10 * i + 1);
            req_b[i*W +: W] = 8'h3C;
        end
        req_valid = 4'hF;
        for (n = 0; n < 100; n++) begin
            @(posedge clk);
            if (acc_ids.size() - base >= 5) break;
        end
        if (n == 100) checkOutput("rr_timeout", 32'd0, 32'd1);
        #1;
        req_valid = '0;
        waitIdle();
        for (int i = 0; i < 5; i++) begin
            if (base + i < acc_ids.size()) checkOutput("rr_order", acc_ids[base+i], rr_exp[i]);
            else checkOutput("rr_missing", 32'd0, 32'd1);
        end
        checkOutput("rr_ptr_after", {30'b0, dut.rr_ptr}, 32'd1);

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(1, 8'hC3, 8'h96);
        req_a[3*W +: W] = 8'h11;
        req_b[3*W +: W] = 8'h22;
        req_valid[3]    = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
        checkOutput("bp_hold_y", {24'b0, rsp_y}, 32'h0000_0055);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        waitReady(3);
        waitIdle();
        checkOutput("bp_id_first", acc_ids[acc_ids.size()-2], 32'd1);
        checkOutput("bp_id_second", last_id, 32'd3);
        checkOutput("bp_y_second", {24'b0, last_y}, 32'h0000_0033);

        $display("[TB] reset mid-operation");
        applyStimulus(1, 8'hFF, 8'h01);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_ptr", {30'b0, dut.rr_ptr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(3, 8'h5A, 8'hC3);
        waitIdle();
        checkOutput("midrst_new_id", last_id, 32'd3);
        checkOutput("midrst_new_y", {24'b0, last_y}, 32'h0000_0099);

`ifdef XOR_ENGINE_STATS_EN
        $display("[TB] statistics");
        doReset(2);
        @(negedge clk);
        checkOutput("cnt_rst", {16'b0, op_count}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i, 8'(i), 8'h80);
            waitIdle();
        end
        checkOutput("cnt_three", {16'b0, op_count}, 32'd3);
        rsp_ready = 1'b0;
        applyStimulus(0, 8'h07, 8'h00);
        @(posedge clk);
        @(negedge clk);
        checkOutput("parity_odd", {31'b0, op_parity}, {31'b0, ^(8'h07)});
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        waitIdle();
        force dut.op_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.op_count;
        applyStimulus(1, 8'h01, 8'h02);
        waitIdle();
        checkOutput("cnt_wrap", {16'b0, op_count}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
